// File: rtl/cpu_defs.sv
// Shared CPU-wide constants: default word/opcode widths, the NOP encoding
// (also the IR reset value) and a constant-foldable clog2 helper.
package cpu_defs;

  localparam int WORD_W   = 8;
  localparam int OPCODE_W = 4;

  localparam logic [WORD_W-1:0] NOP = 8'h00;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular prefetch queue between program memory and the IR.
// Occupancy is tracked by an explicit counter so full/empty never rely on pointer compare.
module prefetch_fifo
  import cpu_defs::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_fire;
  logic             pop_fire;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Flush beats both handshakes; a full queue refuses pushes even when popping.
  assign push_fire = push && !full && !flush;
  assign pop_fire  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ir_prefetch.sv
// Instruction register fed from a small prefetch queue; load pops the head into
// the IR, flush discards queued words, and the IR is split into opcode/operand.
module ir_prefetch
  import cpu_defs::*;
#(
  parameter  int WIDTH       = WORD_W,
  parameter  int DEPTH       = 4,
  parameter  int OPCODE_BITS = OPCODE_W,
  localparam int CNT_W       = clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_valid,
  input  logic [WIDTH-1:0]       fetch_data,
  output logic                   fetch_ready,
  input  logic                   load,
  input  logic                   flush,
  output logic [WIDTH-1:0]       instr_out,
  output logic [OPCODE_BITS-1:0] opcode,
  output logic [WIDTH-OPCODE_BITS-1:0] operand,
  output logic                   ir_valid,
  output logic                   stall,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;

  prefetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fetch_valid),
    .push_data (fetch_data),
    .pop       (load),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign fetch_ready = !full;
  assign stall       = load && empty && !flush;
  assign instr_out   = ir_q;
  assign ir_valid    = ir_valid_q;
  assign opcode      = ir_q[WIDTH-1 -: OPCODE_BITS];
  assign operand     = ir_q[WIDTH-OPCODE_BITS-1:0];

  // Popped word lands in the IR; a stalled load keeps the old word but marks it stale.
  always_comb begin
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    if (flush) begin
      ir_valid_d = 1'b0;
    end else if (load) begin
      if (!empty) begin
        ir_d       = head;
        ir_valid_d = 1'b1;
      end else begin
        ir_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q       <= WIDTH'(NOP);
      ir_valid_q <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

endmodule

// File: tb/tb_ir_prefetch.sv
// Directed bench for ir_prefetch with hand-computed expected values.
module tb_ir_prefetch;

  logic       clk;
  logic       reset;
  logic       fetch_valid;
  logic [7:0] fetch_data;
  logic       fetch_ready;
  logic       load;
  logic       flush;
  logic [7:0] instr_out;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       ir_valid;
  logic       stall;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int compared   = 0;
  int mismatched = 0;

  ir_prefetch #(
    .WIDTH       (8),
    .DEPTH       (4),
    .OPCODE_BITS (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_ready (fetch_ready),
    .load        (load),
    .flush       (flush),
    .instr_out   (instr_out),
    .opcode      (opcode),
    .operand     (operand),
    .ir_valid    (ir_valid),
    .stall       (stall),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive a new input set at the falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic fv, input logic [7:0] fd,
                               input logic ld, input logic fl);
    @(negedge clk);
    fetch_valid = fv;
    fetch_data  = fd;
    load        = ld;
    flush       = fl;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [7:0] word);
    applyStimulus(1'b1, word, 1'b0, 1'b0);
    stepClock();
  endtask

  task automatic loadWord(input string tag, input logic [7:0] expected_ir,
                          input logic [2:0] expected_count);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    stepClock();
    checkOutput({tag, "_ir"}, instr_out, expected_ir);
    checkOutput({tag, "_valid"}, ir_valid, 1'b1);
    checkOutput({tag, "_count"}, count, expected_count);
  endtask

  initial begin
    reset       = 1'b1;
    fetch_valid = 1'b0;
    fetch_data  = 8'h00;
    load        = 1'b0;
    flush       = 1'b0;
    #2;
    checkOutput("rst_ir", instr_out, 8'h00);
    checkOutput("rst_valid", ir_valid, 1'b0);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_ready", fetch_ready, 1'b1);
    checkOutput("rst_count", count, 3'd0);
    checkOutput("rst_full", full, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Basic fetch
    pushWord(8'hA3);
    pushWord(8'h1C);
    checkOutput("basic_count2", count, 3'd2);
    loadWord("basic_a3", 8'hA3, 3'd1);
    checkOutput("basic_opcode", opcode, 4'hA);
    checkOutput("basic_operand", operand, 4'h3);
    loadWord("basic_1c", 8'h1C, 3'd0);

    // Fill to full, then offer a word that must be refused
    pushWord(8'h11);
    pushWord(8'h22);
    pushWord(8'h33);
    pushWord(8'h44);
    checkOutput("full_flag", full, 1'b1);
    checkOutput("full_ready", fetch_ready, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    stepClock();
    checkOutput("full_hold_count", count, 3'd4);
    loadWord("drain_11", 8'h11, 3'd3);
    loadWord("drain_22", 8'h22, 3'd2);
    loadWord("drain_33", 8'h33, 3'd1);
    loadWord("drain_44", 8'h44, 3'd0);

    // Empty load with same-cycle push: no bypass
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    #1;
    checkOutput("empty_stall", stall, 1'b1);
    stepClock();
    checkOutput("empty_ir_hold", instr_out, 8'h44);
    checkOutput("empty_valid", ir_valid, 1'b0);
    checkOutput("empty_count", count, 3'd1);
    loadWord("after_stall_77", 8'h77, 3'd0);

    // Pointer wrap
    pushWord(8'h66);
    loadWord("wrap_66", 8'h66, 3'd0);

    // Simultaneous push and pop
    pushWord(8'hAA);
    pushWord(8'hBB);
    applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0);
    stepClock();
    checkOutput("simul_ir", instr_out, 8'hAA);
    checkOutput("simul_count", count, 3'd2);
    loadWord("simul_bb", 8'hBB, 3'd1);
    loadWord("simul_cc", 8'hCC, 3'd0);

    // Flush outranks push and load
    pushWord(8'hD1);
    pushWord(8'hD2);
    pushWord(8'hD3);
    checkOutput("preflush_count", count, 3'd3);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1);
    #1;
    checkOutput("flush_no_stall", stall, 1'b0);
    stepClock();
    checkOutput("flush_count", count, 3'd0);
    checkOutput("flush_ir", instr_out, 8'hCC);
    checkOutput("flush_valid", ir_valid, 1'b0);
    checkOutput("flush_empty", empty, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    checkOutput("postflush_stall", stall, 1'b1);
    stepClock();
    checkOutput("postflush_ir", instr_out, 8'hCC);
    checkOutput("postflush_count", count, 3'd0);

    // Asynchronous reset in the middle of traffic
    pushWord(8'h12);
    pushWord(8'h34);
    loadWord("prereset_12", 8'h12, 3'd1);
    applyStimulus(1'b1, 8'h9F, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_ir", instr_out, 8'h00);
    checkOutput("midrst_valid", ir_valid, 1'b0);
    checkOutput("midrst_count", count, 3'd0);
    checkOutput("midrst_empty", empty, 1'b1);
    checkOutput("midrst_ready", fetch_ready, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    pushWord(8'h56);
    loadWord("postrst_56", 8'h56, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
